// File: rtl/scalar_pkg.sv
// ============================================================================
// scalar_pkg : shared widths and types for the scalar write-back path
// Revision   : 1.0
// ============================================================================
`default_nettype none

package scalar_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;
endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2  : two-requester round-robin arbiter, pointer flips on contention
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import scalar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  src_e pri_q;
  src_e pri_d;

  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | (pri_q == SRC_ALU));
    gnt_o[1] = req_i[1] & (~req_i[0] | (pri_q == SRC_MEM));
    pri_d    = pri_q;
    // Uncontested grants leave the pointer alone.
    if (req_i[0] && req_i[1]) begin
      pri_d = (pri_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pri_q <= SRC_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/scalar_wb_ctrl.sv
// ============================================================================
// scalar_wb_ctrl : ALU/load write-back arbiter, registered RF write port and
//                  pending-write scoreboard with three hazard query ports
// Revision       : 1.0
// ============================================================================
`default_nettype none

module scalar_wb_ctrl
  import scalar_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ALU_VALID,
  input  logic [ADDR_W-1:0] ALU_RD,
  input  logic [DATA_W-1:0] ALU_WD,
  output logic              ALU_READY,
  input  logic              MEM_VALID,
  input  logic [ADDR_W-1:0] MEM_RD,
  input  logic [DATA_W-1:0] MEM_WD,
  output logic              MEM_READY,
  input  logic              ISSUE_VALID,
  input  logic [ADDR_W-1:0] ISSUE_RD,
  output logic              ISSUE_READY,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  input  logic [ADDR_W-1:0] RS3,
  output logic              HAZ1,
  output logic              HAZ2,
  output logic              HAZ3,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WD,
  output logic              WES
);

  logic [1:0]      gnt;
  wb_req_t         out_q;
  wb_req_t         out_d;
  logic            wes_q;
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic            issue_ok;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({MEM_VALID, ALU_VALID}),
    .gnt_o (gnt)
  );

  assign ALU_READY   = gnt[0];
  assign MEM_READY   = gnt[1];
  assign issue_ok    = ISSUE_VALID & ~pend_q[ISSUE_RD];
  assign ISSUE_READY = issue_ok;

  always_comb begin
    out_d = out_q;
    if (gnt[1]) begin
      out_d = '{rd: MEM_RD, wd: MEM_WD};
    end else if (gnt[0]) begin
      out_d = '{rd: ALU_RD, wd: ALU_WD};
    end
  end

  // Set is applied after clear so a same-edge allocation survives the commit.
  always_comb begin
    pend_d = pend_q;
    if (wes_q) begin
      pend_d[out_q.rd] = 1'b0;
    end
    if (issue_ok) begin
      pend_d[ISSUE_RD] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wes_q  <= 1'b0;
      out_q  <= '0;
      pend_q <= '0;
    end else begin
      wes_q  <= |gnt;
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end

  assign RD   = out_q.rd;
  assign WD   = out_q.wd;
  assign WES  = wes_q;
  assign HAZ1 = pend_q[RS1];
  assign HAZ2 = pend_q[RS2];
  assign HAZ3 = pend_q[RS3];

endmodule

`default_nettype wire

// File: tb/tb_scalar_wb_ctrl.sv
// ============================================================================
// tb_scalar_wb_ctrl : directed self-checking bench for scalar_wb_ctrl
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_scalar_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ALU_VALID, MEM_VALID, ISSUE_VALID;
  logic [4:0]  ALU_RD, MEM_RD, ISSUE_RD, RS1, RS2, RS3;
  logic [15:0] ALU_WD, MEM_WD;
  logic        ALU_READY, MEM_READY, ISSUE_READY;
  logic        HAZ1, HAZ2, HAZ3, WES;
  logic [4:0]  RD;
  logic [15:0] WD;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scalar_wb_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ALU_VALID   (ALU_VALID),
    .ALU_RD      (ALU_RD),
    .ALU_WD      (ALU_WD),
    .ALU_READY   (ALU_READY),
    .MEM_VALID   (MEM_VALID),
    .MEM_RD      (MEM_RD),
    .MEM_WD      (MEM_WD),
    .MEM_READY   (MEM_READY),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_RD    (ISSUE_RD),
    .ISSUE_READY (ISSUE_READY),
    .RS1         (RS1),
    .RS2         (RS2),
    .RS3         (RS3),
    .HAZ1        (HAZ1),
    .HAZ2        (HAZ2),
    .HAZ3        (HAZ3),
    .RD          (RD),
    .WD          (WD),
    .WES         (WES)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    ALU_VALID = 0; MEM_VALID = 0; ISSUE_VALID = 0;
    ALU_RD = 0; MEM_RD = 0; ISSUE_RD = 0; ALU_WD = 0; MEM_WD = 0;
    RS1 = 0; RS2 = 0; RS3 = 0;
    #12;
    chk("rst_wes", WES, 0);
    chk("rst_rd", RD, 0);
    chk("rst_wd", WD, 0);
    chk("rst_haz", {HAZ1, HAZ2, HAZ3}, 0);
    rst = 1'b1;

    // Preload pend with R3 and R7, with a write in flight
    ISSUE_VALID = 1; ISSUE_RD = 3; RS1 = 3; RS2 = 7; RS3 = 1;
    step();
    ISSUE_RD = 7; ALU_VALID = 1; ALU_RD = 4; ALU_WD = 16'hAAAA;
    step();
    ISSUE_VALID = 0; ALU_VALID = 0;
    chk("pre_haz1", HAZ1, 1);
    chk("pre_haz2", HAZ2, 1);
    chk("pre_wes", WES, 1);
    chk("pre_rd", RD, 4);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_wes", WES, 0);
    chk("mid_rst_rd", RD, 0);
    chk("mid_rst_wd", WD, 0);
    chk("mid_rst_haz", {HAZ1, HAZ2, HAZ3}, 0);
    #1 rst = 1'b1;
    ISSUE_VALID = 1; ISSUE_RD = 3;
    #1;
    chk("iss3_ready", ISSUE_READY, 1);
    step();
    chk("iss3_haz1", HAZ1, 1);
    chk("iss3_waw", ISSUE_READY, 0);
    ISSUE_VALID = 0;

    // Single ALU write
    RS1 = 0; RS2 = 0; RS3 = 0;
    ALU_VALID = 1; ALU_RD = 5; ALU_WD = 16'h1234;
    #1;
    chk("alu_ready", ALU_READY, 1);
    chk("alu_mem_ready", MEM_READY, 0);
    step();
    ALU_VALID = 0;
    chk("alu_wes", WES, 1);
    chk("alu_rd", RD, 5);
    chk("alu_wd", WD, 16'h1234);
    step();
    chk("alu_wes_drop", WES, 0);
    chk("alu_rd_hold", RD, 5);

    // Contested alternation from reset
    #3 rst = 1'b0;
    #1 rst = 1'b1;
    ALU_VALID = 1; ALU_RD = 1; ALU_WD = 16'h0011;
    MEM_VALID = 1; MEM_RD = 2; MEM_WD = 16'h0022;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_alu_ready", ALU_READY, (i % 2 == 0) ? 1 : 0);
      chk("alt_mem_ready", MEM_READY, (i % 2 == 1) ? 1 : 0);
      step();
      chk("alt_wes", WES, 1);
      chk("alt_rd", RD, (i % 2 == 0) ? 1 : 2);
    end
    ALU_VALID = 0; MEM_VALID = 1;
    #1;
    chk("mem_alone_ready", MEM_READY, 1);
    step();
    chk("mem_alone_rd", RD, 2);
    ALU_VALID = 1;
    #1;
    chk("pri_hold_alu", ALU_READY, 1);
    chk("pri_hold_mem", MEM_READY, 0);
    step();
    ALU_VALID = 0; MEM_VALID = 0;
    step();
    chk("alt_idle_wes", WES, 0);

    // Scoreboard hazard on R9
    ISSUE_VALID = 1; ISSUE_RD = 9; RS2 = 9;
    #1;
    chk("iss9_ready", ISSUE_READY, 1);
    chk("iss9_haz2_pre", HAZ2, 0);
    step();
    chk("iss9_haz2", HAZ2, 1);
    chk("iss9_waw", ISSUE_READY, 0);
    MEM_VALID = 1; MEM_RD = 9; MEM_WD = 16'hBEEF;
    #1;
    chk("mem9_ready", MEM_READY, 1);
    step();
    MEM_VALID = 0;
    chk("mem9_wes", WES, 1);
    chk("mem9_rd", RD, 9);
    chk("mem9_wd", WD, 16'hBEEF);
    chk("mem9_haz2_n1", HAZ2, 1);
    chk("mem9_waw_n1", ISSUE_READY, 0);
    ISSUE_VALID = 0;
    step();
    chk("mem9_haz2_n2", HAZ2, 0);
    chk("mem9_wes_drop", WES, 0);

    // Commit to non-pending R12
    RS1 = 12; RS2 = 9; RS3 = 5;
    ALU_VALID = 1; ALU_RD = 12; ALU_WD = 16'h00FF;
    step();
    ALU_VALID = 0;
    chk("np_wes", WES, 1);
    chk("np_rd", RD, 12);
    chk("np_wd", WD, 16'h00FF);
    chk("np_haz", {HAZ1, HAZ2, HAZ3}, 0);
    step();
    chk("np_haz_after", {HAZ1, HAZ2, HAZ3}, 0);
    ISSUE_VALID = 1; ISSUE_RD = 12;
    #1;
    chk("np_iss12_ready", ISSUE_READY, 1);
    step();
    ISSUE_VALID = 0;
    chk("np_iss12_haz1", HAZ1, 1);

    // Reset while a write is in flight; PRI is MEM-first before it
    ALU_VALID = 1; ALU_RD = 21; ALU_WD = 16'h5555;
    step();
    ALU_VALID = 0;
    chk("fl_wes", WES, 1);
    #3 rst = 1'b0;
    #1;
    chk("fl_wes_drop", WES, 0);
    chk("fl_rd", RD, 0);
    chk("fl_haz1", HAZ1, 0);
    #1 rst = 1'b1;
    ALU_VALID = 1; MEM_VALID = 1; ALU_RD = 1; MEM_RD = 2;
    #1;
    chk("fl_pri_alu", ALU_READY, 1);
    chk("fl_pri_mem", MEM_READY, 0);
    step();
    ALU_VALID = 0; MEM_VALID = 0;
    chk("fl_first_rd", RD, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scalar_wb_ctrl.md
# scalar_wb_ctrl

Write-back controller for the scalar register file. Arbitrates one register-file write per cycle between the scalar ALU and the load unit through a valid/ready handshake, and drives the register file's RD/WD/WES write port from a registered output stage. Keeps a 32-entry pending-write scoreboard, set by the issue stage and cleared on commit, and answers hazard queries for the three read addresses RS1/RS2/RS3.

## Interface
- DATA_W, 16, write data width
- ADDR_W, 5, register address width
- NREG, 32, number of scalar registers (2**ADDR_W)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- ALU_VALID  in  1  ALU write request
- ALU_RD  in  ADDR_W  ALU destination register
- ALU_WD  in  DATA_W  ALU result
- ALU_READY  out  1  ALU request granted this cycle
- MEM_VALID  in  1  load-unit write request
- MEM_RD  in  ADDR_W  load destination register
- MEM_WD  in  DATA_W  load data
- MEM_READY  out  1  load request granted this cycle
- ISSUE_VALID  in  1  issue stage allocates a destination
- ISSUE_RD  in  ADDR_W  destination being allocated
- ISSUE_READY  out  1  allocation accepted
- RS1, RS2, RS3  in  ADDR_W  read addresses under hazard check
- HAZ1, HAZ2, HAZ3  out  1  pending write to RSn
- RD  out  ADDR_W  register-file write address
- WD  out  DATA_W  register-file write data
- WES  out  1  register-file write enable

## Operation
- Sources hold VALID, RD, and WD stable until READY. READY is combinational from VALID, the priority pointer, and the other source's VALID. A transfer happens on a cycle with VALID&READY.
- Arbitration:
  - One source valid: that source is granted.
  - Both valid: the source named by the priority pointer PRI is granted, and PRI flips to the other source. PRI is 0 for ALU, 1 for MEM.
  - PRI changes only on a contested grant.
- Output stage: a granted request loads {RD, WD} and sets WES=1 for exactly the next cycle. With no grant, WES=0 and RD/WD hold their last values. The register file always accepts, so there is no back-pressure from the output.
- Scoreboard pend[NREG]:
  - ISSUE_READY = ISSUE_VALID & !pend[ISSUE_RD]. This blocks WAW allocation.
  - An accepted issue sets pend[ISSUE_RD].
  - A commit (WES=1) clears pend[RD] at the end of that cycle.
  - Same edge, set and clear of the same register: set wins. This case cannot arise through ISSUE_READY; state it for robustness.
  - A commit to a non-pending register is legal: the register file is written and the scoreboard is unchanged.
- HAZn = pend[RSn], combinational. No bypass: consumers stall while HAZn=1.
- Register 0 gets no special treatment.

## Timing
- Reset (rst=0, asynchronous):
  - WES=0, RD=0, WD=0, pend all 0, PRI=0.
  - ALU_READY, MEM_READY, ISSUE_READY, and HAZn follow their equations; with pend=0, HAZn=0.
  - An in-flight output write is dropped.
- Grant on edge N → WES=1 with RD/WD during cycle N+1 → register file updated at edge N+1 and pend cleared at edge N+1. HAZ for that register is 0 from cycle N+2, when reads return the new value.
- Issue accepted at edge N → HAZ=1 for that register from cycle N+1.
- Throughput: one write per cycle sustained. Two continuously valid sources alternate grants.
- Reset release: first grant possible on the first rising edge with rst=1.

## Structure
- Shared package scalar_pkg: DATA_W, ADDR_W, NREG constants; typedef wb_req_t {rd, wd}; typedef src_e {SRC_ALU, SRC_MEM}.
- Sub-module rr_arb2 (two-requester round-robin arbiter with PRI flop and clk/rst).
- Scoreboard, issue check, and output stage stay in scalar_wb_ctrl.

## Test plan
- Reset with pend pre-loaded by issues to R3 and R7, then rst=0 mid-cycle → WES=0, RD=0, WD=0, HAZ all 0 immediately; ISSUE_RD=3 accepted after release.
- ALU_VALID alone, RD=5, WD=16'h1234 → ALU_READY=1; next cycle WES=1, RD=5, WD=16'h1234; following cycle WES=0.
- Both valid for 4 cycles from reset, ALU RD=1 and MEM RD=2 → grants ALU, MEM, ALU, MEM; WES high 4 consecutive cycles with RD 1, 2, 1, 2.
- Issue R9; RS2=9 → HAZ2=1 from next cycle; MEM writes R9 with 16'hBEEF → HAZ2 drops two cycles after grant; second ISSUE_RD=9 before the commit → ISSUE_READY=0.
- ALU write to non-pending R12 with 16'h00FF → WES=1, RD=12, WD=16'h00FF; pend unchanged, all HAZ=0.
- Grant on edge N, rst=0 during cycle N+1 → WES falls immediately, pend cleared, PRI=0.
